// File: rtl/register_file_scan.sv
// register_file_scan: parametrised register file with two registered read ports,
// one write port (destination select), optional write-first bypass, optional
// hard-wired zero register and a sequential scan engine for debug display.
// Ports:
//   CLK, RESET                        clock, synchronous active-high reset
//   read_register1/2                  read addresses (read_register2 is also the write address when regdst=0)
//   destination_register, regdst      write address when regdst=1, write-address select
//   regwritedata, regwrite            write data and enable
//   scan_start                        request a full register dump
//   readdata1/2                       registered read data
//   scan_busy/valid/addr/data/done    scan stream outputs
module register_file_scan #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int BYPASS   = 0,
    parameter int ZERO_REG = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] read_register1,
    input  logic [ADDR_W-1:0] read_register2,
    input  logic [ADDR_W-1:0] destination_register,
    input  logic              regdst,
    input  logic [DATA_W-1:0] regwritedata,
    input  logic              regwrite,
    input  logic              scan_start,
    output logic [DATA_W-1:0] readdata1,
    output logic [DATA_W-1:0] readdata2,
    output logic              scan_busy,
    output logic              scan_valid,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_done
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, SCAN} state_t;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [ADDR_W-1:0] waddr;
    logic              wen;
    logic [ADDR_W-1:0] ra   [3];
    logic [DATA_W-1:0] rdat [3];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              last;
    logic [DATA_W-1:0] rd1_q, rd2_q, sdata_q, sdata_d;
    logic [ADDR_W-1:0] saddr_q, saddr_d;
    logic              svalid_q, svalid_d, sdone_q, sdone_d;

    assign waddr = regdst ? destination_register : read_register2;
    // A write to the zero register is dropped entirely, so it can never bypass either.
    assign wen   = regwrite && !(ZERO_REG != 0 && waddr == '0);

    // Three lookups share the same zero/bypass rules: port 1, port 2, scan index.
    assign ra[0] = read_register1;
    assign ra[1] = read_register2;
    assign ra[2] = idx_q;

    for (genvar i = 0; i < 3; i++) begin : g_rd
        assign rdat[i] = (ZERO_REG != 0 && ra[i] == '0) ? '0 :
                         (BYPASS != 0 && wen && ra[i] == waddr) ? regwritedata : regs_q[ra[i]];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            if (wen) regs_q[waddr] <= regwritedata;
            rd1_q <= rdat[0];
            rd2_q <= rdat[1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            svalid_q <= 1'b0;
            saddr_q  <= '0;
            sdata_q  <= '0;
            sdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            svalid_q <= svalid_d;
            saddr_q  <= saddr_d;
            sdata_q  <= sdata_d;
            sdone_q  <= sdone_d;
        end
    end

    assign last = idx_q == ADDR_W'(DEPTH - 1);

    // The index wraps to 0 on the last entry, so it is already cleared for the next scan.
    always_comb begin
        state_d = state_q == IDLE ? (scan_start ? SCAN : IDLE) : (last ? IDLE : SCAN);
        idx_d   = state_q == IDLE ? '0 : idx_q + 1'b1;
    end

    always_comb begin
        svalid_d = state_q == SCAN;
        saddr_d  = state_q == SCAN ? idx_q : saddr_q;
        sdata_d  = state_q == SCAN ? rdat[2] : sdata_q;
        sdone_d  = state_q == SCAN && last;
    end

    assign readdata1  = rd1_q;
    assign readdata2  = rd2_q;
    assign scan_busy  = state_q == SCAN;
    assign scan_valid = svalid_q;
    assign scan_addr  = saddr_q;
    assign scan_data  = sdata_q;
    assign scan_done  = sdone_q;
endmodule

// File: doc/register_file_scan.md
# register_file_scan

Parametrised successor to the CPU's 4×8 general-purpose register file. It provides:
- two registered read ports and one write port with destination select;
- optional write-to-read bypass and an optional hard-wired zero register;
- a sequential scan engine that streams every register out, one per cycle, for the board's LED/7-segment debug display.

It sits between the instruction decoder (register fields) and the ALU/writeback path.

## Interface
Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W registers
- BYPASS, 0, 1 = read returns same-cycle write data (write-first); 0 = read returns pre-write value (read-first)
- ZERO_REG, 0, 1 = register 0 reads as 0 and ignores writes

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  reset, synchronous and active-high
- read_register1  in  ADDR_W  read port 1 address
- read_register2  in  ADDR_W  read port 2 address; also the write address when regdst=0
- destination_register  in  ADDR_W  write address when regdst=1
- regdst  in  1  write-address select
- regwritedata  in  DATA_W  write data
- regwrite  in  1  write enable
- scan_start  in  1  request a full register dump
- readdata1  out  DATA_W  registered read data, port 1
- readdata2  out  DATA_W  registered read data, port 2
- scan_busy  out  1  scan in progress
- scan_valid  out  1  scan_addr/scan_data valid this cycle
- scan_addr  out  ADDR_W  index of the streamed register
- scan_data  out  DATA_W  contents of the streamed register
- scan_done  out  1  one-cycle pulse with the last scan entry

## Operation
- **Write address:** waddr = regdst ? destination_register : read_register2.
- **Write:** on an edge with regwrite=1, registers[waddr] <= regwritedata.
  - With ZERO_REG=1 and waddr=0 the write is discarded.
- **Reads:** readdata1/2 are loaded every edge from the addressed register; there is no read enable.
  - Bypass: with BYPASS=1, a regwrite=1 in the same cycle, and read address == waddr (and the write not discarded), the output loads regwritedata.
  - With BYPASS=0 the output loads the old contents.
  - With ZERO_REG=1, address 0 always reads 0.
- **Both read ports** may address the same register; both return identical data.
- **Scan FSM** has two states, IDLE and SCAN, and an index counter idx.
  - IDLE: scan_start=1 moves to SCAN with idx=0. Otherwise stay in IDLE.
  - SCAN, each edge: scan_valid<=1, scan_addr<=idx, scan_data<=contents of idx. scan_data uses the same bypass/zero rules as the read ports.
  - SCAN, idx==DEPTH-1: scan_done<=1, return to IDLE.
  - SCAN, otherwise: idx<=idx+1.
  - scan_start is ignored while in SCAN (no restart, no queueing).
- **Concurrency:** scans never block reads or writes. A write to an already-streamed index is not re-reported.
- **Reset:**
  - all registers = 0;
  - readdata1 = readdata2 = 0;
  - state = IDLE, idx = 0;
  - scan_valid = scan_done = 0, scan_addr = 0, scan_data = 0.
- **Reset mid-scan** aborts the scan at the next edge. No scan_done is produced.
- RESET has priority over regwrite and scan_start in the same cycle.

## Timing
- **Read latency:** 1 cycle. An address presented before edge E appears on readdata after E.
- **Write:** visible to a read issued in the cycle after the writing edge.
  - Same-cycle visibility exists only with BYPASS=1.
- **Scan timing:** scan_start high at edge E0 in IDLE gives:
  - scan_busy=1 from after E0 until after E_DEPTH;
  - entry i (i=0..DEPTH-1) valid after edge E(i+1);
  - scan_done=1 only after E_DEPTH, coincident with the last valid entry;
  - scan_valid low after E(DEPTH+1) unless a new scan is started.
- **Back-to-back scans:** scan_start held high continuously gives back-to-back scans with a 1-cycle IDLE gap. The next start is sampled in the IDLE cycle after E_DEPTH.
- **Pulse widths:** scan_valid is high exactly DEPTH cycles per scan; scan_done is high exactly 1 cycle.

## Test plan
1. **Reset/read:** defaults; RESET 1 cycle, then read addresses 0..3 -> readdata1=readdata2=0x00; scan outputs all 0.
2. **Write/readback and regdst:**
   - regdst=1, dest=2, data 0xA5, regwrite=1;
   - then regdst=0, read_register2=3, data 0x3C;
   - read r2/r3 next cycle -> readdata1=0xA5, readdata2=0x3C.
3. **Bypass:** write 0x11 to r1, then in one cycle write 0x77 to r1 while reading r1 on both ports.
   - BYPASS=0 -> 0x11 on both ports.
   - BYPASS=1 -> 0x77 on both ports.
   - Either way, next-cycle read -> 0x77.
4. **Zero register:** ZERO_REG=1; write 0xFF to r0 -> read r0 = 0x00 on both ports and scan entry 0 = 0x00.
5. **Scan:** load r0..r3 = 0x10,0x20,0x30,0x40; pulse scan_start.
   - Outputs -> 4 consecutive valid cycles with addr 0..3 and data 0x10..0x40.
   - scan_done only with addr 3; busy 4 cycles.
   - A second scan_start mid-scan is ignored.
6. **Reset mid-scan / params:** assert RESET during entry 1 -> next cycle scan_valid=0, busy=0, no scan_done, registers 0. Repeat scenario 5 with DATA_W=16, ADDR_W=3 -> 8 entries, scan_done with addr 7.
